// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and load/store.
// One transaction at a time: grant, issue, wait fixed read latency, acknowledge.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_ack,
    output logic [DW-1:0]     if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW/8-1:0]   d_we,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    output logic [DW/8-1:0]   mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);
    localparam int BW = DW / 8;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic            last_gnt;     // 1 = data port won the previous grant
    logic            winner;       // 1 = data port owns the current transaction
    logic            grant;
    logic            grant_d;
    logic [3:0]      lat_cnt;
    logic [AW-1:0]   req_addr;
    logic [BW-1:0]   req_we;
    logic [DW-1:0]   req_wdata;

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant    = 1'b1;
                    // On a tie the port that did not win last time goes first
                    grant_d  = d_req && (!if_req || !last_gnt);
                    state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = (req_we != '0) ? RESP : WAIT;
            WAIT:    if (lat_cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
            winner   <= 1'b0;
            lat_cnt  <= 4'd0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (grant) winner <= grant_d;
            if (state == ISSUE) begin
                last_gnt <= winner;
                lat_cnt  <= LAT_INIT;
            end
            if (state == WAIT) begin
                if (lat_cnt != 4'd0) begin
                    lat_cnt <= lat_cnt - 4'd1;
                end else if (winner) begin
                    d_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Request payload is only visible on the memory bus during ISSUE, so it needs no reset
    always_ff @(posedge clk) begin
        if (grant) begin
            req_addr  <= grant_d ? d_addr : if_addr;
            req_we    <= grant_d ? d_we : '0;
            req_wdata <= grant_d ? d_wdata : '0;
        end
    end

    always_comb begin
        mem_en    = (state == ISSUE);
        mem_addr  = mem_en ? req_addr : '0;
        mem_we    = mem_en ? req_we : '0;
        mem_wdata = mem_en ? req_wdata : '0;
        if_ack    = (state == RESP) && !winner;
        d_ack     = (state == RESP) && winner;
        if_stall  = if_req && !if_ack;
        d_stall   = d_req && !d_ack;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the instruction-fetch requester and the load/store (data) requester.
- Used when the RV32I core moves from split imem/dmem to a single memory array.
- Sequences each access (issue, wait fixed latency, respond), arbitrates round-robin on contention, and generates per-requester stall.
- Sits between the CPU core (fetch unit and L/S-type datapath) and the memory macro.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte-enable width is DW/8.
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  AW  fetch byte address.
- if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid this cycle.
- if_rdata  out  DW  fetched word.
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request; d_addr/d_we/d_wdata held stable until d_ack.
- d_addr  in  AW  data byte address.
- d_we  in  DW/8  byte write enables; 0 means read.
- d_wdata  in  DW  store data, already lane-replicated by the core.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DW  load word, valid with d_ack on reads.
- d_stall  out  1  d_req & ~d_ack.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_addr  out  AW  memory address.
- mem_we  out  DW/8  memory byte write enables.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: FSM=IDLE, last_gnt=FETCH, lat_cnt=0. All outputs 0: acks, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata.
- Stalls are combinational from req and ack; they are 0 whenever req is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that is not last_gnt. After reset the first tie therefore goes to DATA.
  - On grant, latch addr, we and wdata into internal registers (fetch we forced to 0), record the winner, go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_addr/mem_we/mem_wdata driven from the latched request.
  - last_gnt <= winner.
  - Write (latched we!=0): go to RESP.
  - Read: lat_cnt <= MEM_LAT-1, go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0.
  - Decrement lat_cnt.
  - When lat_cnt==0, capture mem_rdata into the winner's rdata register and go to RESP.
  - With MEM_LAT=1, WAIT lasts exactly one cycle.
- RESP (1 cycle):
  - Winner's ack=1; the other ack stays 0.
  - Go to IDLE. Requests are not sampled in RESP.
  - A requester must drop or change its request after ack. A new request is arbitrated at the earliest in the following IDLE cycle.
- Latency (request first seen in IDLE at cycle T, no contention):
  - Read: mem_en at T+1, ack at T+2+MEM_LAT.
  - Write: mem_en at T+1, ack at T+2.
- if_rdata/d_rdata hold their last captured value between acks; the non-winner's rdata is unchanged.
- Boundary conditions:
  - Request withdrawn mid-transaction: the transaction still completes and ack still pulses; the requester ignores it.
  - Request inputs changing after grant: no effect (latched copies are used).
  - Reset in any state, including WAIT with a read in flight: next cycle IDLE with all outputs 0, no ack, in-flight data discarded.
  - Simultaneous reset and req: reset wins.
  - Address alignment: addresses pass through unmodified; alignment is the core's responsibility.
- Fairness: under continuous contention grants alternate DATA, FETCH, DATA, ... Each requester waits at most one other transaction.

Test Plan:
- Fetch read, MEM_LAT=2: if_req=1, if_addr=0x0000_0010 at cycle 0; memory returns 0xDEADBEEF at cycle 3 -> mem_en=1 with mem_addr=0x10 and mem_we=0 at cycle 1; if_ack=1 with if_rdata=0xDEADBEEF at cycle 4; if_stall=1 during cycles 0-3.
- Store: d_req=1, d_addr=0x100, d_we=4'b0011, d_wdata=0x1234_1234 at cycle 0 -> mem_en=1 with mem_we=0011 and mem_wdata=0x12341234 at cycle 1; d_ack at cycle 2; if_ack stays 0.
- Contention after reset: if_req and d_req both held from cycle 0 -> data read issued first (mem_en cycle 1, d_ack cycle 4), fetch issued at cycle 6; three further back-to-back contended pairs alternate the grant.
- Reset mid-read: assert reset at cycle 2 of a fetch read (in WAIT) -> cycle 3 all outputs 0, state IDLE, no if_ack ever pulses for that request.
- Withdrawn request: d_req pulses for cycle 0 only, as a read -> transaction completes, d_ack at cycle 4, then the block idles with no further mem_en.
- MEM_LAT=1 build: fetch read at cycle 0 -> mem_en at cycle 1, capture at cycle 2, if_ack at cycle 3.
